ppf_commutator: RTL

Input commutator for the direct-form polyphase filter bank. It accepts a single serial stream of signed samples with a valid/ready handshake and distributes each group of CH_NUM consecutive samples across the CH_NUM polyphase branches. It emits one parallel frame with a one-cycle `data_valid_o` strobe, in the form `ppf_top` consumes on `data_valid_i` / `channelN_data_i`. It sits between the ADC/DDC sample source and `ppf_top`.

---
 rtl/ppf_pkg.sv | 14 +
 rtl/ppf_commutator.sv | 103 ++++++++++
 2 files changed

// File: rtl/ppf_pkg.sv
// Shared types and defaults for the polyphase filter bank input path.
package ppf_pkg;

   localparam int PPF_CH_NUM = 8;
   localparam int PPF_DW     = 32;

   typedef logic signed [PPF_DW-1:0] ppf_sample_t;

   typedef enum logic {
      ST_WAIT_SYNC = 1'b0,
      ST_FILL      = 1'b1
   } ppf_cmt_state_e;

endpackage

// File: rtl/ppf_commutator.sv
// Serial-to-parallel input commutator for the polyphase filter bank.
// Define PPF_COMMUTATOR_DESCEND_EN to map phase k to branch CH_NUM-1-k instead of k.
//
// state        | meaning
// ST_WAIT_SYNC | discard samples until one arrives flagged with s_sync_i
// ST_FILL      | collect CH_NUM samples per frame, emit frame on the last one
module ppf_commutator
   import ppf_pkg::*;
#(
   parameter int CH_NUM = PPF_CH_NUM,
   parameter int DW     = PPF_DW,
   parameter int FCNT_W = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       en_i,
   input  logic                       s_valid_i,
   input  logic [DW-1:0]              s_data_i,
   input  logic                       s_sync_i,
   output logic                       s_ready_o,
   output logic                       data_valid_o,
   output logic [CH_NUM-1:0][DW-1:0]  channel_data_o,
   output logic                       sync_err_o,
   output logic [FCNT_W-1:0]          frame_cnt_o
);

   localparam int              PH_W    = $clog2(CH_NUM);
   localparam logic [PH_W-1:0] PH_ZERO = '0;
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CH_NUM - 1);

   function automatic logic [PH_W-1:0] branch_of(input logic [PH_W-1:0] ph);
`ifdef PPF_COMMUTATOR_DESCEND_EN
      return PH_LAST - ph;
`else
      return ph;
`endif
   endfunction

   ppf_cmt_state_e            state_q;
   logic [PH_W-1:0]           phase_q;
   logic [CH_NUM-1:0][DW-1:0] stage_q;
   logic [CH_NUM-1:0][DW-1:0] frame_d;
   logic                      accept;
   logic                      sync_mid;
   logic                      last_phase;

   assign accept     = s_valid_i & s_ready_o;
   assign sync_mid   = s_sync_i & (phase_q != PH_ZERO);
   assign last_phase = (phase_q == PH_LAST);

   // The closing sample bypasses staging straight into the output frame.
   always_comb begin
      frame_d                    = stage_q;
      frame_d[branch_of(PH_LAST)] = s_data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q        <= ST_WAIT_SYNC;
         phase_q        <= PH_ZERO;
         stage_q        <= '0;
         s_ready_o      <= 1'b0;
         data_valid_o   <= 1'b0;
         channel_data_o <= '0;
         sync_err_o     <= 1'b0;
         frame_cnt_o    <= '0;
      end else begin
         s_ready_o    <= en_i;
         data_valid_o <= 1'b0;
         sync_err_o   <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_WAIT_SYNC: begin
                  if (s_sync_i) begin
                     stage_q[branch_of(PH_ZERO)] <= s_data_i;
                     phase_q                     <= PH_ONE;
                     state_q                     <= ST_FILL;
                  end
               end
               ST_FILL: begin
                  if (sync_mid) begin
                     // Restart the frame; stale staging entries get overwritten before use.
                     sync_err_o                  <= 1'b1;
                     stage_q[branch_of(PH_ZERO)] <= s_data_i;
                     phase_q                     <= PH_ONE;
                  end else if (last_phase) begin
                     channel_data_o <= frame_d;
                     data_valid_o   <= 1'b1;
                     frame_cnt_o    <= frame_cnt_o + FCNT_W'(1);
                     phase_q        <= PH_ZERO;
                  end else begin
                     stage_q[branch_of(phase_q)] <= s_data_i;
                     phase_q                     <= phase_q + PH_ONE;
                  end
               end
               default: state_q <= ST_WAIT_SYNC;
            endcase
         end
      end
   end

endmodule
